// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  // One fetch-queue entry: the word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc,inst} queue with push, pop and a flush that overrides both.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       push_entry,
  output fetch_entry_t       head_entry_c,
  output logic               full_c,
  output logic               empty_c,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty_c;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full_c | do_pop);

  assign head_entry_c = empty_c ? fetch_entry_t'('0) : mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC and ROM enable, queues fetched words for decode,
// and redirects on branch requests from execute.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter  logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      rom_addr_o,
  output logic             rom_ce_o,
  input  logic [31:0]      rom_data_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_inst_o,
  output logic [PTR_W:0]   fetch_count_o
);

  logic [31:0]    pc;
  logic           ce;
  logic           pop_c;
  logic           fetch_c;
  logic           fifo_full_c;
  logic           fifo_empty_c;
  logic [PTR_W:0] fifo_count;
  fetch_entry_t   push_entry_c;
  fetch_entry_t   head_entry_c;
  logic           unused_target_lsbs;

  // Word-aligned targets only; the byte offset is dropped on redirect.
  assign unused_target_lsbs = &{1'b0, branch_target_i[1:0]};

  assign pop_c   = ~fifo_empty_c & id_ready_i;
  assign fetch_c = ce & ~branch_flag_i & (~fifo_full_c | pop_c);

  assign push_entry_c.pc   = pc;
  assign push_entry_c.inst = rom_data_i;

  // PC and chip enable; a branch loads the PC even before the ROM is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ce <= 1'b0;
    end else begin
      ce <= 1'b1;
      if (branch_flag_i) begin
        pc <= {branch_target_i[31:2], 2'b00};
      end else if (fetch_c) begin
        pc <= next_pc(pc);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (fetch_c),
    .pop          (pop_c),
    .flush        (branch_flag_i),
    .push_entry   (push_entry_c),
    .head_entry_c (head_entry_c),
    .full_c       (fifo_full_c),
    .empty_c      (fifo_empty_c),
    .count        (fifo_count)
  );

  assign rom_addr_o    = pc;
  assign rom_ce_o      = ce;
  assign id_valid_o    = ~fifo_empty_c;
  assign id_pc_o       = head_entry_c.pc;
  assign id_inst_o     = head_entry_c.inst;
  assign fetch_count_o = fifo_count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a queue-based reference model predicts
// every fetched entry; a negedge monitor compares the DUT against it.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b1;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  fetch_count_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  if_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_addr_o      (rom_addr_o),
    .rom_ce_o        (rom_ce_o),
    .rom_data_i      (rom_data_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .fetch_count_o   (fetch_count_o)
  );

  // Reference model: expected queue of {pc, inst} plus the expected PC and enable.
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] m_pc = RST_PC;
  logic        m_ce = 1'b0;

  always @(posedge clk) begin
    bit m_pop;
    bit m_fetch;
    if (rst) begin
      m_pc = RST_PC;
      m_ce = 1'b0;
      exp_pc_q.delete();
      exp_inst_q.delete();
    end else begin
      m_pop   = (exp_pc_q.size() > 0) && id_ready_i;
      m_fetch = m_ce && !branch_flag_i && ((exp_pc_q.size() < DEPTH) || m_pop);
      if (branch_flag_i) begin
        exp_pc_q.delete();
        exp_inst_q.delete();
        m_pc = branch_target_i & 32'hFFFF_FFFC;
      end else begin
        if (m_pop) begin
          void'(exp_pc_q.pop_front());
          void'(exp_inst_q.pop_front());
        end
        if (m_fetch) begin
          exp_pc_q.push_back(m_pc);
          exp_inst_q.push_back(rom_word(m_pc));
          m_pc = m_pc + 32'd4;
        end
      end
      m_ce = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented output against the model away from the edge.
  always @(negedge clk) begin
    check("rom_ce", 32'(rom_ce_o), 32'(m_ce));
    check("rom_addr", rom_addr_o, m_pc);
    check("count", 32'(fetch_count_o), 32'(exp_pc_q.size()));
    check("id_valid", 32'(id_valid_o), 32'(exp_pc_q.size() != 0));
    if (exp_pc_q.size() != 0) begin
      check("id_pc", id_pc_o, exp_pc_q[0]);
      check("id_inst", id_inst_o, exp_inst_q[0]);
    end else begin
      check("id_pc_empty", id_pc_o, 32'h0);
      check("id_inst_empty", id_inst_o, 32'h0);
    end
  end

  task automatic drive(input logic r, input logic b, input logic [31:0] t,
                       input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      rst             = r;
      branch_flag_i   = b;
      branch_target_i = t;
      id_ready_i      = rdy;
    end
  endtask

  initial begin
    // Streaming with decode always ready.
    drive(1, 0, 0, 1, 2);
    drive(0, 0, 0, 1, 20);
    // Stall from reset: queue fills to depth, then drains in order.
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 10);
    drive(0, 0, 0, 1, 8);
    // Full queue with a single pop: fetch continues, nothing lost.
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 8);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 6);
    // Branch with three queued entries and a pop in the same cycle.
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 4);
    drive(0, 1, 32'h0000_0103, 1, 1);
    drive(0, 0, 0, 1, 6);
    // Branch during the cycle right after reset release.
    drive(1, 0, 0, 1, 1);
    drive(0, 1, 32'h0000_0040, 1, 1);
    drive(0, 0, 0, 1, 4);
    // PC wrap across the top of the address space.
    drive(0, 1, 32'hFFFF_FFFB, 1, 1);
    drive(0, 0, 0, 1, 6);
    // Reset mid-stream with a full queue.
    drive(0, 0, 0, 0, 8);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 5);
    // Random traffic: ready, branches with random targets, rare resets.
    for (int i = 0; i < 600; i++) begin
      int unsigned roll;
      roll = $urandom_range(0, 99);
      drive(roll < 1 ? 1'b1 : 1'b0,
            (roll >= 1 && roll < 7) ? 1'b1 : 1'b0,
            (roll == 6) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom(),
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            1);
    end
    drive(0, 0, 0, 1, 3);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
